// File: rtl/fdiv16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fdiv16_pkg                                                |
// | Purpose  : Shared constants, FSM state encoding, rounding-mode and   |
// |            flag-bit encodings, and FP16 operand classification for   |
// |            the fdiv16 divider.                                       |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package fdiv16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RM  = 2'b10;
  localparam logic [1:0] RM_RP  = 2'b11;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [15:0] QNAN   = 16'h7e00;
  localparam logic [15:0] MAXFIN = 16'h7bff;
  localparam int unsigned ITERS  = 13;

  typedef struct packed {
    logic is_zero;   // true zero or subnormal (subnormals flush to zero)
    logic is_inf;
    logic is_nan;
    logic is_snan;
  } fp16_class_t;

  // Classify the magnitude bits of an FP16 value.
  function automatic fp16_class_t fp16_classify(input logic [14:0] mag);
    fp16_class_t c;
    c.is_zero = (mag[14:10] == 5'd0);
    c.is_inf  = (mag[14:10] == 5'h1f) && (mag[9:0] == 10'd0);
    c.is_nan  = (mag[14:10] == 5'h1f) && (mag[9:0] != 10'd0);
    c.is_snan = c.is_nan && !mag[9];
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fdiv16_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fdiv16_if                                                 |
// | Purpose  : Operand/result handshake bundle for fdiv16.               |
// | Ports    : in_valid/in_ready/x/y/roundMode  - operand channel        |
// |            out_valid/out_ready/result/flags - result channel         |
// |            modport master : producer/consumer side (testbench, SoC)  |
// |            modport slave  : divider side                             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface fdiv16_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [1:0]  roundMode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  modport master (
    output in_valid, x, y, roundMode, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, x, y, roundMode, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface
`default_nettype wire

// File: rtl/fdiv16_round.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fdiv16_round                                              |
// | Purpose  : Combinational rounding plus overflow/underflow result     |
// |            selection for the fdiv16 quotient.                        |
// | Ports    : sign    - result sign                                     |
// |            exp_in  - normalized unbiased+15 exponent (7-bit signed)  |
// |            sig     - 11-bit significand incl. hidden bit             |
// |            guard/sticky - rounding bits                              |
// |            mode    - rounding mode                                   |
// |            result/flags - packed FP16 result and {NV,OF,UF,NX}       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fdiv16_round
  import fdiv16_pkg::*;
(
  input  logic              sign,
  input  logic signed [6:0] exp_in,
  input  logic [10:0]       sig,
  input  logic              guard,
  input  logic              sticky,
  input  logic [1:0]        mode,
  output logic [15:0]       result,
  output logic [3:0]        flags
);

  logic              inexact;
  logic              inc;
  logic [11:0]       sum;
  logic signed [6:0] exp_r;
  logic [9:0]        frac;
  logic              to_inf;

  always_comb begin
    inexact = guard | sticky;
    inc     = 1'b0;
    case (mode)
      RM_RZ:   inc = 1'b0;
      RM_RNE:  inc = guard & (sticky | sig[0]);
      RM_RM:   inc = sign & inexact;
      RM_RP:   inc = ~sign & inexact;
      default: inc = 1'b0;
    endcase

    sum = {1'b0, sig} + {11'd0, inc};
    // Carry out of 1.111..1 leaves 10.000..0: bump exponent, fraction is 0.
    exp_r = exp_in + (sum[11] ? 7'sd1 : 7'sd0);
    frac  = sum[11] ? sum[10:1] : sum[9:0];

    to_inf = (mode == RM_RNE) | ((mode == RM_RP) & ~sign) | ((mode == RM_RM) & sign);

    result = {sign, exp_r[4:0], frac};
    flags  = 4'd0;
    flags[FLAG_NX] = inexact;

    if (exp_r >= 7'sd31) begin
      result = to_inf ? {sign, 5'h1f, 10'd0} : {sign, MAXFIN[14:0]};
      flags[FLAG_OF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else if (exp_r <= 7'sd0) begin
      // No subnormal outputs: anything below the normal range flushes.
      result = {sign, 15'd0};
      flags[FLAG_UF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fdiv16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fdiv16                                                    |
// | Purpose  : Iterative FP16 divider, radix-2 restoring, one quotient   |
// |            bit per cycle, with valid/ready operand and result        |
// |            channels.                                                 |
// | Ports    : clk     - clock, rising edge                              |
// |            reset_n - synchronous active-low reset                    |
// |            bus     - fdiv16_if.slave handshake bundle                |
// | Config   : FDIV16_BACK2BACK_EN - accept a new operand pair in the    |
// |            same cycle the previous result retires (no bubble).       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fdiv16
  import fdiv16_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  fdiv16_if.slave bus
);

  localparam logic [3:0] CNT_FIRST = 4'(ITERS - 1);

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] rem_q, rem_d;
  logic [12:0] quo_q, quo_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;

  logic        in_ready_w;
  logic        accept;

  // ---------------- handshake ----------------
`ifdef FDIV16_BACK2BACK_EN
  assign in_ready_w = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
`else
  assign in_ready_w = (state_q == ST_IDLE);
`endif
  assign accept = bus.in_valid & in_ready_w;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  // ---------------- special-case detection on incoming operands ----------------
  fp16_class_t cx, cy;
  logic        special;
  logic        sign_in;
  logic        nan_case;
  logic [15:0] spec_result;
  logic [3:0]  spec_flags;

  assign cx      = fp16_classify(bus.x[14:0]);
  assign cy      = fp16_classify(bus.y[14:0]);
  assign sign_in = bus.x[15] ^ bus.y[15];
  assign special = cx.is_zero | cx.is_inf | cx.is_nan | cy.is_zero | cy.is_inf | cy.is_nan;
  assign nan_case = cx.is_nan | cy.is_nan | (cx.is_zero & cy.is_zero) | (cx.is_inf & cy.is_inf);

  always_comb begin
    spec_result = {sign_in, 15'd0};
    spec_flags  = 4'd0;
    if (nan_case) begin
      spec_result = QNAN;
      // A quiet NaN input propagates silently; invalid ops and sNaN raise NV.
      spec_flags[FLAG_NV] = cx.is_snan | cy.is_snan | (cx.is_zero & cy.is_zero) |
                            (cx.is_inf & cy.is_inf);
    end else if (cy.is_zero | cx.is_inf) begin
      spec_result = {sign_in, 5'h1f, 10'd0};
    end
  end

  // ---------------- restoring divide step ----------------
  logic [11:0] rem_cur;
  logic [11:0] divisor;
  logic        take;
  logic [11:0] rem_sub;
  logic [11:0] rem_step;

  // The first step seeds the partial remainder with 1.mx from the operand register.
  assign rem_cur  = (cnt_q == CNT_FIRST) ? {2'b01, x_q[9:0]} : rem_q;
  assign divisor  = {2'b01, y_q[9:0]};
  assign take     = (rem_cur >= divisor);
  assign rem_sub  = take ? (rem_cur - divisor) : rem_cur;
  assign rem_step = rem_sub << 1;

  // ---------------- normalization ----------------
  logic signed [6:0] exp_raw;
  logic signed [6:0] exp_norm;
  logic [10:0]       sig;
  logic              guard;
  logic              sticky;
  logic [15:0]       rnd_result;
  logic [3:0]        rnd_flags;

  assign exp_raw  = $signed({2'b00, x_q[14:10]}) - $signed({2'b00, y_q[14:10]}) + 7'sd15;
  // Quotient of two [1,2) significands lies in (0.5,2); q[12] is the integer bit.
  assign exp_norm = quo_q[12] ? exp_raw : (exp_raw - 7'sd1);
  assign sig      = quo_q[12] ? quo_q[12:2] : quo_q[11:1];
  assign guard    = quo_q[12] ? quo_q[1] : quo_q[0];
  assign sticky   = (quo_q[12] & quo_q[0]) | (rem_q != 12'd0);

  fdiv16_round u_round (
    .sign   (x_q[15] ^ y_q[15]),
    .exp_in (exp_norm),
    .sig    (sig),
    .guard  (guard),
    .sticky (sticky),
    .mode   (mode_q),
    .result (rnd_result),
    .flags  (rnd_flags)
  );

  // ---------------- next state ----------------
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_ITER: begin
        rem_d = rem_step;
        quo_d = {quo_q[11:0], take};
        if (cnt_q == 4'd0) begin
          state_d = ST_ROUND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ROUND: begin
        result_d = rnd_result;
        flags_d  = rnd_flags;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept can only occur in IDLE, or in DONE while retiring (back-to-back build).
    if (accept) begin
      x_d    = bus.x;
      y_d    = bus.y;
      mode_d = bus.roundMode;
      if (special) begin
        state_d  = ST_DONE;
        result_d = spec_result;
        flags_d  = spec_flags;
      end else begin
        state_d = ST_ITER;
        cnt_d   = CNT_FIRST;
        rem_d   = 12'd0;
        quo_d   = 13'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      x_q      <= 16'd0;
      y_q      <= 16'd0;
      mode_q   <= 2'd0;
      cnt_q    <= 4'd0;
      rem_q    <= 12'd0;
      quo_q    <= 13'd0;
      result_q <= 16'd0;
      flags_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fdiv16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fdiv16                                                 |
// | Purpose  : Directed self-checking bench for fdiv16: reset values,    |
// |            normal quotients in all rounding modes, special cases,    |
// |            overflow/underflow, latency, output hold, mid-op reset    |
// |            and (FDIV16_BACK2BACK_EN) back-to-back issue.             |
// | Ports    : none                                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_fdiv16;
  import fdiv16_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  fdiv16_if bus ();

  fdiv16 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm);
    bus.in_valid  = 1'b1;
    bus.x         = a;
    bus.y         = b;
    bus.roundMode = rm;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.x         = 16'hdead;
    bus.y         = 16'hbeef;
    bus.roundMode = 2'($urandom);
  endtask

  // Edges from the accepting edge until out_valid is seen; 0 if it never rises.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] rm, input logic [15:0] exp_res,
                        input logic [3:0] exp_fl, input int exp_lat);
    int lat;
    check({tag, "/in_ready"}, {15'd0, bus.in_ready}, 16'h0001);
    start_op(a, b, rm);
    wait_valid(lat);
    check({tag, "/latency"}, 16'(lat), 16'(exp_lat));
    check({tag, "/result"}, bus.result, exp_res);
    check({tag, "/flags"}, {12'd0, bus.flags}, {12'd0, exp_fl});
    retire();
    check({tag, "/retired"}, {15'd0, bus.out_valid}, 16'h0000);
  endtask

  initial begin
    int lat;
    int seen;

    bus.in_valid  = 1'b0;
    bus.x         = 16'd0;
    bus.y         = 16'd0;
    bus.roundMode = RM_RNE;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst/out_valid", {15'd0, bus.out_valid}, 16'h0000);
    check("rst/in_ready", {15'd0, bus.in_ready}, 16'h0001);
    check("rst/result", bus.result, 16'h0000);
    check("rst/flags", {12'd0, bus.flags}, 16'h0000);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Normal path
    run_op("1/2_rne",    16'h3c00, 16'h4000, RM_RNE, 16'h3800, 4'b0000, 14);
    run_op("1/3_rne",    16'h3c00, 16'h4200, RM_RNE, 16'h3555, 4'b0001, 14);
    run_op("1/3_rp",     16'h3c00, 16'h4200, RM_RP,  16'h3556, 4'b0001, 14);
    run_op("1/3_rz",     16'h3c00, 16'h4200, RM_RZ,  16'h3555, 4'b0001, 14);
    run_op("-1/3_rm",    16'hbc00, 16'h4200, RM_RM,  16'hb556, 4'b0001, 14);
    run_op("-1/3_rp",    16'hbc00, 16'h4200, RM_RP,  16'hb555, 4'b0001, 14);
    run_op("5/2",        16'h4500, 16'h4000, RM_RNE, 16'h4100, 4'b0000, 14);
    run_op("-5/2",       16'hc500, 16'h4000, RM_RZ,  16'hc100, 4'b0000, 14);

    // Overflow / underflow
    run_op("ovf_rne",    16'h7bff, 16'h3800, RM_RNE, 16'h7c00, 4'b0101, 14);
    run_op("ovf_rz",     16'h7bff, 16'h3800, RM_RZ,  16'h7bff, 4'b0101, 14);
    run_op("ovf_neg_rm", 16'hfbff, 16'h3800, RM_RM,  16'hfc00, 4'b0101, 14);
    run_op("ovf_neg_rp", 16'hfbff, 16'h3800, RM_RP,  16'hfbff, 4'b0101, 14);
    run_op("unf",        16'h0400, 16'h4000, RM_RNE, 16'h0000, 4'b0011, 14);

    // Special cases
    run_op("0/0",        16'h0000, 16'h0000, RM_RNE, 16'h7e00, 4'b1000, 1);
    run_op("1/-0",       16'h3c00, 16'h8000, RM_RNE, 16'hfc00, 4'b0000, 1);
    run_op("qnan",       16'h7e00, 16'h3c00, RM_RNE, 16'h7e00, 4'b0000, 1);
    run_op("snan",       16'h3c00, 16'h7c01, RM_RNE, 16'h7e00, 4'b1000, 1);
    run_op("inf/inf",    16'h7c00, 16'hfc00, RM_RNE, 16'h7e00, 4'b1000, 1);
    run_op("inf/-2",     16'h7c00, 16'hc000, RM_RNE, 16'hfc00, 4'b0000, 1);
    run_op("1/inf",      16'h3c00, 16'h7c00, RM_RNE, 16'h0000, 4'b0000, 1);
    run_op("-0/1",       16'h8000, 16'h3c00, RM_RNE, 16'h8000, 4'b0000, 1);
    run_op("sub/1",      16'h0001, 16'h3c00, RM_RNE, 16'h0000, 4'b0000, 1);
    run_op("1/sub",      16'h3c00, 16'h0001, RM_RNE, 16'h7c00, 4'b0000, 1);

    // Output hold while stalled
    start_op(16'h3c00, 16'h4000, RM_RNE);
    wait_valid(lat);
    check("hold/latency", 16'(lat), 16'd14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold/out_valid", {15'd0, bus.out_valid}, 16'h0001);
      check("hold/result", bus.result, 16'h3800);
      check("hold/flags", {12'd0, bus.flags}, 16'h0000);
      check("hold/in_ready", {15'd0, bus.in_ready}, 16'h0000);
    end

`ifdef FDIV16_BACK2BACK_EN
    // Retire and accept on the same edge
    bus.out_ready = 1'b1;
    #0;
    check("b2b/in_ready", {15'd0, bus.in_ready}, 16'h0001);
    start_op(16'h4500, 16'h4000, RM_RNE);
    bus.out_ready = 1'b0;
    wait_valid(lat);
    check("b2b/latency", 16'(lat), 16'd14);
    check("b2b/result", bus.result, 16'h4100);
    retire();
`else
    // Without back-to-back, retiring does not open the operand channel
    bus.out_ready = 1'b1;
    #0;
    check("nob2b/in_ready", {15'd0, bus.in_ready}, 16'h0000);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("nob2b/idle_ready", {15'd0, bus.in_ready}, 16'h0001);
`endif

    // Reset during ITER aborts the operation
    start_op(16'h3c00, 16'h4200, RM_RNE);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midrst/in_ready", {15'd0, bus.in_ready}, 16'h0001);
    check("midrst/result", bus.result, 16'h0000);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("midrst/no_valid", 16'(seen), 16'd0);
    check("midrst/ready_after", {15'd0, bus.in_ready}, 16'h0001);

    // Operation after abort completes normally
    run_op("post_rst",   16'h3c00, 16'h4000, RM_RNE, 16'h3800, 4'b0000, 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/fdiv16.md
FDIV16 -- requirements
Module: fdiv16

Interface
REQ-001 The block SHALL have no parameters; all constants SHALL come from fdiv16_pkg.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 x  input  16  FP16 dividend.
REQ-007 y  input  16  FP16 divisor.
REQ-008 roundMode  input  2  rounding mode: 00 RZ, 01 RNE, 10 RM (toward -inf), 11 RP (toward +inf).
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  16  FP16 quotient x/y.
REQ-012 flags  output  4  {NV, OF, UF, NX}, bit 3 down to bit 0.

Function
REQ-013 A handshake (in_valid & in_ready) SHALL capture x, y and roundMode into registers; the inputs are don't-care afterwards.
REQ-014 The FSM SHALL have states IDLE, ITER, ROUND, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 IDLE->ITER on handshake with finite nonzero operands; IDLE->DONE on handshake with a special-case operand; ITER->ROUND when the iteration counter reaches 0; ROUND->DONE always; DONE->IDLE on out_ready.
REQ-016 ITER SHALL run a radix-2 restoring divide of 1.mx by 1.my, producing 1 quotient bit per cycle for exactly 13 cycles (q[12:0]).
REQ-017 Normalization: if q[12]=1, significand=q[12:2], guard=q[1], sticky=q[0]|(remainder!=0); otherwise significand=q[11:1], guard=q[0], sticky=(remainder!=0), and the exponent is decremented by 1.
REQ-018 The unbiased exponent SHALL be computed as ex-ey+15 in a 7-bit signed width; the result sign SHALL be xs^ys.
REQ-019 ROUND SHALL apply roundMode using guard/sticky; a mantissa carry-out SHALL increment the exponent. NX=guard|sticky.
REQ-020 If the exponent is >=31 after rounding: OF|NX. Result SHALL be signed inf for RNE, for RP when positive, and for RM when negative; otherwise it SHALL be 7bff with the sign applied.
REQ-021 If the exponent is <=0: the result SHALL be signed zero with UF|NX (flush, no subnormal output).
REQ-022 Subnormal operands SHALL be treated as signed zero.
REQ-023 Special cases:
  - any NaN operand, 0/0 or inf/inf: 7e00 with NV set only if an operand is sNaN or the case is 0/0 or inf/inf;
  - finite/0 and inf/finite: signed inf, flags 0;
  - finite/inf and 0/finite: signed zero, flags 0.
REQ-024 Latency: normal path out_valid SHALL rise 14 edges after the accepting edge; special path 1 edge after.
REQ-025 result and flags SHALL hold stable while out_valid & ~out_ready.

Reset
REQ-026 When reset_n=0 at a rising edge: state=IDLE, out_valid=0, result=0000, flags=0000, counter=0, operand registers=0.
REQ-027 Reset mid-ITER/ROUND/DONE SHALL abort the operation with no result emitted; in_ready=1 on the first edge after reset_n returns high.

Configuration
REQ-028 With FDIV16_BACK2BACK_EN defined: in_ready = IDLE | (DONE & out_ready); a simultaneous retire and accept SHALL go directly from DONE to ITER, or to DONE for a special case, with no idle cycle.
REQ-029 Without FDIV16_BACK2BACK_EN: in_ready=1 only in IDLE, giving one bubble cycle between operations.

Structure
REQ-030 fdiv16_pkg SHALL hold the state enum, the roundMode encodings, the flag bit indices, QNAN=16'h7e00, MAXFIN=16'h7bff, and ITERS=13.
REQ-031 Rounding, overflow and underflow selection SHALL live in one combinational sub-module, fdiv16_round; the FSM, datapath and special-case detection SHALL stay in fdiv16.

Verification
REQ-032 x=3c00, y=4000, RNE -> result 3800, flags 0000, out_valid exactly 14 edges after accept.
REQ-033 x=3c00, y=4200, RNE -> 3555, flags 0001; same operands with RP -> 3556, flags 0001; with RZ -> 3555.
REQ-034 x=0000, y=0000 -> 7e00, flags 1000, one edge after accept; x=3c00, y=8000 -> fc00, flags 0000.
REQ-035 x=7bff, y=3800: RNE -> 7c00, flags 0101; RZ -> 7bff, flags 0101.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> result and flags unchanged, in_ready=0; assert reset_n=0 during ITER -> out_valid never rises, in_ready=1 after release.
REQ-037 With FDIV16_BACK2BACK_EN: in_valid and out_ready both high in DONE -> next op accepted that edge, second result 14 edges later.
